// File: rtl/gate_test_pkg.sv
// Shared definitions for the basic-gate self-test sequencer: FSM states,
// gate output bit positions and the truth-table reference used in CHECK.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    // Bit positions of each gate inside the 7-bit result bus
    localparam int AND_BIT  = 0;
    localparam int OR_BIT   = 1;
    localparam int NOT_BIT  = 2;
    localparam int NAND_BIT = 3;
    localparam int NOR_BIT  = 4;
    localparam int XOR_BIT  = 5;
    localparam int XNOR_BIT = 6;

    localparam int NUM_VECTORS = 4;

    // Truth-table value every healthy gate unit must produce for inputs (a,b);
    // NOT only looks at input a.
    function automatic logic [6:0] gate_expected(input logic a, input logic b);
        logic [6:0] e;
        e           = '0;
        e[AND_BIT]  = a & b;
        e[OR_BIT]   = a | b;
        e[NOT_BIT]  = ~a;
        e[NAND_BIT] = ~(a & b);
        e[NOR_BIT]  = ~(a | b);
        e[XOR_BIT]  = a ^ b;
        e[XNOR_BIT] = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/gate_selftest_ctrl.sv
// In-circuit self-test sequencer for the two-input basic-gate unit.
// Walks the four (a,b) vectors, lets each settle, compares the seven gate
// outputs against the truth table and reports sticky pass/fail masks.
module gate_selftest_ctrl
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       gate_a,
    output logic       gate_b,
    input  logic [6:0] gate_res,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_mask,
    output logic [3:0] err_vec
);

    // Counter value on the last settle cycle of a vector
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

    state_t     state;
    logic [1:0] vec_idx;
    logic [7:0] settle_cnt;
    logic [1:0] next_idx;
    logic [6:0] diff;

    // The gate inputs are registered copies of the vector index bits, so the
    // expected pattern can be taken straight from what is being driven.
    assign next_idx = vec_idx + 2'd1;
    assign diff     = gate_res ^ gate_expected(gate_a, gate_b);

    // Single sequencer FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec_idx    <= 2'd0;
            settle_cnt <= 8'd0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_mask   <= 7'd0;
            err_vec    <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state      <= SETTLE;
                        vec_idx    <= 2'd0;
                        settle_cnt <= 8'd0;
                        gate_a     <= 1'b0;
                        gate_b     <= 1'b0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_mask   <= 7'd0;
                        err_vec    <= 4'd0;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        state      <= IDLE;
                        vec_idx    <= 2'd0;
                        settle_cnt <= 8'd0;
                        gate_a     <= 1'b0;
                        gate_b     <= 1'b0;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    if (abort) begin
                        state      <= IDLE;
                        vec_idx    <= 2'd0;
                        settle_cnt <= 8'd0;
                        gate_a     <= 1'b0;
                        gate_b     <= 1'b0;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                    end else begin
                        err_mask         <= err_mask | diff;
                        err_vec[vec_idx] <= err_vec[vec_idx] | (|diff);
                        if (vec_idx == LAST_VEC) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= ((err_mask | diff) == 7'd0);
                            gate_a <= 1'b0;
                            gate_b <= 1'b0;
                        end else begin
                            state      <= SETTLE;
                            vec_idx    <= next_idx;
                            settle_cnt <= 8'd0;
                            gate_a     <= next_idx[1];
                            gate_b     <= next_idx[0];
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Self-checking bench for gate_selftest_ctrl: an emulated gate unit with
// injectable stuck-at faults, a truth-table reference model, and directed
// plus randomized runs on two instances (SETTLE_CYCLES 2 and 1).
module tb_gate_selftest_ctrl;

    localparam int S_A = 2;
    localparam int S_B = 1;

    logic       clk;
    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b;
    logic       gate_a_a, gate_b_a, gate_a_b, gate_b_b;
    logic [6:0] gate_res_a, gate_res_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [6:0] err_mask_a, err_mask_b;
    logic [3:0] err_vec_a, err_vec_b;
    logic [6:0] stuck0, stuck1;

    int checks = 0;
    int errors = 0;

    // Reference truth table written directly from the gate definitions
    function automatic logic [6:0] gold(input logic a, input logic b);
        logic [6:0] r;
        r[0] = a & b;
        r[1] = a | b;
        r[2] = !a;
        r[3] = !(a & b);
        r[4] = !(a | b);
        r[5] = a ^ b;
        r[6] = !(a ^ b);
        return r;
    endfunction

    // Emulated gate unit for instance A with stuck-at-0 / stuck-at-1 masks
    function automatic logic [6:0] faulty(input logic a, input logic b);
        return (gold(a, b) & ~stuck0) | stuck1;
    endfunction

    assign gate_res_a = faulty(gate_a_a, gate_b_a);
    assign gate_res_b = gold(gate_a_b, gate_b_b);

    gate_selftest_ctrl #(.SETTLE_CYCLES(S_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .gate_a(gate_a_a), .gate_b(gate_b_a), .gate_res(gate_res_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_mask(err_mask_a), .err_vec(err_vec_a)
    );

    gate_selftest_ctrl #(.SETTLE_CYCLES(S_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .gate_a(gate_a_b), .gate_b(gate_b_b), .gate_res(gate_res_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_mask(err_mask_b), .err_vec(err_vec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check that instance A holds its reset / idle values
    task automatic check_reset_a(input string tag);
        check_bit({tag, "_busy"}, busy_a, 1'b0);
        check_bit({tag, "_done"}, done_a, 1'b0);
        check_bit({tag, "_pass"}, pass_a, 1'b0);
        check_bit({tag, "_ga"}, gate_a_a, 1'b0);
        check_bit({tag, "_gb"}, gate_b_a, 1'b0);
        check_vec({tag, "_mask"}, err_mask_a, 7'h00);
        check_vec({tag, "_vec"}, 7'(err_vec_a), 7'h00);
    endtask

    // Full run on instance A with the given fault masks, checked cycle by cycle
    task automatic apply_stimulus(input string tag, input logic [6:0] s0, input logic [6:0] s1);
        logic [6:0] exp_mask;
        logic [3:0] exp_vec;
        logic [6:0] d;
        logic [1:0] v;
        stuck0   = s0;
        stuck1   = s1;
        exp_mask = '0;
        exp_vec  = '0;
        for (int i = 0; i < 4; i++) begin
            v          = 2'(i);
            d          = faulty(v[1], v[0]) ^ gold(v[1], v[0]);
            exp_mask  |= d;
            exp_vec[i] = |d;
        end
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= 4 * (S_A + 1) + 1; c++) begin
            @(negedge clk);
            if (c == 1) start_a = 1'b0;
            if (c <= 4 * (S_A + 1)) begin
                v = 2'((c - 1) / (S_A + 1));
                check_bit({tag, "_busy"}, busy_a, 1'b1);
                check_bit({tag, "_done_early"}, done_a, 1'b0);
                check_bit({tag, "_ga"}, gate_a_a, v[1]);
                check_bit({tag, "_gb"}, gate_b_a, v[0]);
            end else begin
                check_bit({tag, "_done"}, done_a, 1'b1);
                check_bit({tag, "_busy_end"}, busy_a, 1'b0);
                check_bit({tag, "_pass"}, pass_a, exp_mask == 7'h00);
                check_vec({tag, "_mask"}, err_mask_a, exp_mask);
                check_vec({tag, "_vec"}, 7'(err_vec_a), 7'(exp_vec));
            end
        end
        @(negedge clk);
        check_bit({tag, "_done_pulse"}, done_a, 1'b0);
        check_vec({tag, "_mask_hold"}, err_mask_a, exp_mask);
        check_bit({tag, "_pass_hold"}, pass_a, exp_mask == 7'h00);
    endtask

    // Compare instance A result outputs against fixed expected values
    task automatic check_output(input string tag, input logic p, input logic [6:0] m, input logic [3:0] vv);
        check_bit({tag, "_pass_k"}, pass_a, p);
        check_vec({tag, "_mask_k"}, err_mask_a, m);
        check_vec({tag, "_vec_k"}, 7'(err_vec_a), 7'(vv));
    endtask

    initial begin
        logic [6:0] r0, r1;
        rst_n   = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        stuck0  = '0;
        stuck1  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check_reset_a("rst");
        check_bit("rst_b_busy", busy_b, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Healthy unit
        apply_stimulus("healthy", 7'h00, 7'h00);
        check_output("healthy", 1'b1, 7'h00, 4'b0000);

        // XOR stuck at 0
        apply_stimulus("xor_s0", 7'h20, 7'h00);
        check_output("xor_s0", 1'b0, 7'h20, 4'b0110);

        // NOT stuck at 1
        apply_stimulus("not_s1", 7'h00, 7'h04);
        check_output("not_s1", 1'b0, 7'h04, 4'b1100);

        // Randomized fault patterns
        for (int n = 0; n < 6; n++) begin
            r0 = 7'($urandom);
            r1 = 7'($urandom) & ~r0;
            if ($urandom_range(0, 2) == 0) begin
                r0 = '0;
                r1 = '0;
            end
            apply_stimulus("rand", r0, r1);
        end

        // start and abort together in IDLE: abort wins
        stuck0 = 7'h20;
        stuck1 = 7'h00;
        @(negedge clk);
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        check_bit("sa_busy", busy_a, 1'b0);

        // Abort during vector 2 settle; partial results kept
        start_a = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) start_a = 1'b0;
        end
        check_bit("ab_pre_ga", gate_a_a, 1'b1);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check_bit("ab_busy", busy_a, 1'b0);
        check_bit("ab_pass", pass_a, 1'b0);
        check_bit("ab_ga", gate_a_a, 1'b0);
        check_bit("ab_gb", gate_b_a, 1'b0);
        check_vec("ab_mask", err_mask_a, 7'h20);
        check_vec("ab_vec", 7'(err_vec_a), 7'h02);
        for (int c = 0; c < 12; c++) begin
            check_bit("ab_no_done", done_a, 1'b0);
            @(negedge clk);
        end

        // Reset during vector 1 check
        stuck0 = 7'h40;
        stuck1 = 7'h00;
        start_a = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start_a = 1'b0;
        end
        check_vec("rc_pre_mask", err_mask_a, 7'h40);
        check_bit("rc_pre_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_a("rc");
        @(negedge clk);
        check_bit("rc_no_done", done_a, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus("after_rst", 7'h00, 7'h00);

        // Back-to-back on instance B with start held high
        start_b = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            check_bit("b2b_done", done_b, (c >= 9) && ((c - 9) % 10 == 0));
            check_bit("b2b_busy", busy_b, ((c - 1) % 10) < 8);
            if (done_b) check_bit("b2b_pass", pass_b, 1'b1);
        end
        start_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
